// File: rtl/fma16_arb.sv
// fma16_arb: round-robin arbiter/sequencer sharing one multi-cycle fma16 datapath among NREQ requesters.
// Define FMA16_ARB_STICKY_EN to build the per-requester sticky exception-flag registers.
module fma16_arb #(
   parameter int NREQ = 2,
   parameter int LAT  = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [16*NREQ-1:0]      req_x,
   input  logic [16*NREQ-1:0]      req_y,
   input  logic [16*NREQ-1:0]      req_z,
   input  logic [4*NREQ-1:0]       req_op,
   input  logic [2*NREQ-1:0]       req_rm,
   output logic [15:0]             fma_x,
   output logic [15:0]             fma_y,
   output logic [15:0]             fma_z,
   output logic [3:0]              fma_op,
   output logic [1:0]              fma_rm,
   input  logic [15:0]             fma_result,
   input  logic [3:0]              fma_flags,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [15:0]             rsp_result,
   output logic [3:0]              rsp_flags,
   input  logic [NREQ-1:0]         flag_clr,
   output logic [4*NREQ-1:0]       flag_sticky
);
   localparam int IW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t state, state_n;
   logic [IW-1:0] last_grant, grant;
   logic found, accept, capture;
   logic [3:0] cnt;
   // scan from farthest to nearest so the nearest valid index after last_grant wins
   always_comb begin
      grant = last_grant;
      found = 1'b0;
      for (int k = NREQ; k >= 1; k--)
         if (req_valid[(int'(last_grant) + k) % NREQ]) begin
            grant = IW'((int'(last_grant) + k) % NREQ);
            found = 1'b1;
         end
   end
   assign accept    = state == IDLE && found;
   assign capture   = state == BUSY && cnt == 4'd0;
   assign req_ready = accept ? NREQ'(1) << grant : '0;
   assign rsp_valid = state == RESP;
   always_comb begin
      state_n = state;
      state_n = accept ? BUSY : capture ? RESP : (rsp_valid && rsp_ready) ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= IW'(NREQ - 1);
         cnt        <= 4'd0;
         fma_x      <= '0;
         fma_y      <= '0;
         fma_z      <= '0;
         fma_op     <= '0;
         fma_rm     <= '0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            last_grant <= grant;
            cnt        <= 4'(LAT - 1);
            fma_x      <= req_x[16*grant +: 16];
            fma_y      <= req_y[16*grant +: 16];
            fma_z      <= req_z[16*grant +: 16];
            fma_op     <= req_op[4*grant +: 4];
            fma_rm     <= req_rm[2*grant +: 2];
         end
         if (state == BUSY && !capture) cnt <= cnt - 4'd1;
         if (capture) begin
            rsp_id     <= last_grant;
            rsp_result <= fma_result;
            rsp_flags  <= fma_flags;
         end
      end
   end
`ifdef FMA16_ARB_STICKY_EN
   // clear takes effect before the OR, so a same-edge clear keeps only the new flags
   always_ff @(posedge clk)
      for (int i = 0; i < NREQ; i++)
         flag_sticky[4*i +: 4] <= reset ? 4'd0 :
            (flag_clr[i] ? 4'd0 : flag_sticky[4*i +: 4]) |
            ((capture && int'(last_grant) == i) ? fma_flags : 4'd0);
`else
   logic unused_clr;
   assign unused_clr  = ^flag_clr;
   assign flag_sticky = '0;
`endif
endmodule

// File: tb/tb_fma16_arb.sv
// tb_fma16_arb: directed checks of fma16_arb (LAT=1 and LAT=3 instances) against a tiny table-driven datapath stand-in.
module tb_fma16_arb;
`ifdef FMA16_ARB_STICKY_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset;
   logic [1:0] req_valid, req_ready, flag_clr;
   logic [31:0] req_x, req_y, req_z;
   logic [7:0] req_op, flag_sticky;
   logic [3:0] req_rm;
   logic [15:0] fma_x, fma_y, fma_z, fma_result, rsp_result;
   logic [3:0] fma_op, fma_flags, rsp_flags;
   logic [1:0] fma_rm;
   logic rsp_valid, rsp_ready;
   logic [0:0] rsp_id;
   logic [1:0] b_req_valid, b_req_ready;
   logic [31:0] b_req_x, b_req_y, b_req_z;
   logic [7:0] b_req_op, b_flag_sticky;
   logic [3:0] b_req_rm;
   logic [15:0] b_fma_x, b_fma_y, b_fma_z, b_fma_result, b_rsp_result;
   logic [3:0] b_fma_op, b_fma_flags, b_rsp_flags;
   logic [1:0] b_fma_rm;
   logic b_rsp_valid, b_rsp_ready;
   logic [0:0] b_rsp_id;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // hand-computed results for the handful of operand sets used here
   function automatic logic [19:0] dp(input logic [15:0] x, input logic [1:0] rm);
      return x == 16'h3C00 ? {4'h0, 16'h4200} :
             x == 16'h3C01 ? {4'h1, (rm == 2'b11 ? 16'h3C03 : 16'h3C02)} :
             x == 16'h7BFF ? {4'h5, 16'h7C00} : 20'h0;
   endfunction
   assign {fma_flags, fma_result}     = dp(fma_x, fma_rm);
   assign {b_fma_flags, b_fma_result} = dp(b_fma_x, b_fma_rm);

   fma16_arb #(.NREQ(2), .LAT(1)) u_a (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_op(req_op), .req_rm(req_rm),
      .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z), .fma_op(fma_op), .fma_rm(fma_rm),
      .fma_result(fma_result), .fma_flags(fma_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .flag_clr(flag_clr), .flag_sticky(flag_sticky)
   );

   fma16_arb #(.NREQ(2), .LAT(3)) u_b (
      .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_x(b_req_x), .req_y(b_req_y), .req_z(b_req_z), .req_op(b_req_op), .req_rm(b_req_rm),
      .fma_x(b_fma_x), .fma_y(b_fma_y), .fma_z(b_fma_z), .fma_op(b_fma_op), .fma_rm(b_fma_rm),
      .fma_result(b_fma_result), .fma_flags(b_fma_flags),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
      .rsp_result(b_rsp_result), .rsp_flags(b_rsp_flags),
      .flag_clr(2'b00), .flag_sticky(b_flag_sticky)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int r, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                          input logic [3:0] op, input logic [1:0] rm);
      req_x[16*r +: 16] = x;
      req_y[16*r +: 16] = y;
      req_z[16*r +: 16] = z;
      req_op[4*r +: 4]  = op;
      req_rm[2*r +: 2]  = rm;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = 2'b00;
      b_req_valid = 2'b00;
      flag_clr = 2'b00;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // one complete LAT=1 transaction on instance A with rsp_ready high
   task automatic op_a(input string tag, input int r, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] z, input logic [3:0] op, input logic [1:0] rm,
                       input logic [1:0] clr, input logic [15:0] er, input logic [3:0] ef);
      set_req(r, x, y, z, op, rm);
      req_valid[r] = 1'b1;
      rsp_ready = 1'b1;
      #1 chk({tag, ".ready"}, 32'(req_ready), 32'(2'b01 << r));
      tick();
      req_valid[r] = 1'b0;
      flag_clr = clr;
      chk({tag, ".busy_valid"}, 32'(rsp_valid), 0);
      chk({tag, ".busy_ready"}, 32'(req_ready), 0);
      chk({tag, ".fma_x"}, 32'(fma_x), 32'(x));
      chk({tag, ".fma_op"}, 32'(fma_op), 32'(op));
      chk({tag, ".fma_rm"}, 32'(fma_rm), 32'(rm));
      tick();
      flag_clr = 2'b00;
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 1);
      chk({tag, ".rsp_result"}, 32'(rsp_result), 32'(er));
      chk({tag, ".rsp_flags"}, 32'(rsp_flags), 32'(ef));
      chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(r));
      tick();
      chk({tag, ".idle_valid"}, 32'(rsp_valid), 0);
   endtask

   initial begin
      req_x = '0; req_y = '0; req_z = '0; req_op = '0; req_rm = '0;
      b_req_x = '0; b_req_y = '0; b_req_z = '0; b_req_op = '0; b_req_rm = '0;
      rsp_ready = 1'b0;
      b_rsp_ready = 1'b1;
      do_reset();
      chk("rst.req_ready", 32'(req_ready), 0);
      chk("rst.rsp_valid", 32'(rsp_valid), 0);
      chk("rst.rsp_id", 32'(rsp_id), 0);
      chk("rst.rsp_result", 32'(rsp_result), 0);
      chk("rst.rsp_flags", 32'(rsp_flags), 0);
      chk("rst.sticky", 32'(flag_sticky), 0);
      chk("rst.fma", {fma_x, fma_op, fma_rm, 10'd0}, 0);

      op_a("single", 0, 16'h3C00, 16'h4000, 16'h3C00, 4'b1100, 2'b01, 2'b00, 16'h4200, 4'h0);
      op_a("rm_rz", 1, 16'h3C01, 16'h3C01, 16'h0000, 4'b1000, 2'b00, 2'b00, 16'h3C02, 4'h1);
      op_a("rm_ru", 0, 16'h3C01, 16'h3C01, 16'h0000, 4'b1000, 2'b11, 2'b00, 16'h3C03, 4'h1);
      chk("idle.fma_rm_hold", 32'(fma_rm), 3);

      do_reset();
      set_req(0, 16'h3C00, 16'h4000, 16'h3C00, 4'b1100, 2'b01);
      set_req(1, 16'h3C01, 16'h3C01, 16'h0000, 4'b1000, 2'b00);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("rr.grant", 32'(req_ready), (i % 2 == 0) ? 1 : 2);
         tick();
         tick();
         chk("rr.rsp_id", 32'(rsp_id), i % 2);
         chk("rr.rsp_result", 32'(rsp_result), (i % 2 == 0) ? 32'h4200 : 32'h3C02);
         tick();
      end
      req_valid = 2'b00;
      chk("rr.sticky", 32'(flag_sticky), STK ? 32'h10 : 0);

      op_a("ovf", 1, 16'h7BFF, 16'h4000, 16'h0000, 4'b1000, 2'b01, 2'b00, 16'h7C00, 4'h5);
      chk("ovf.sticky1", 32'(flag_sticky[7:4]), STK ? 5 : 0);
      chk("ovf.sticky0", 32'(flag_sticky[3:0]), 0);
      op_a("clr", 1, 16'h3C00, 16'h4000, 16'h3C00, 4'b1100, 2'b01, 2'b10, 16'h4200, 4'h0);
      chk("clr.sticky1", 32'(flag_sticky[7:4]), 0);
      op_a("oth", 1, 16'h3C01, 16'h3C01, 16'h0000, 4'b1000, 2'b00, 2'b01, 16'h3C02, 4'h1);
      chk("oth.sticky1", 32'(flag_sticky[7:4]), STK ? 1 : 0);

      set_req(0, 16'h3C00, 16'h4000, 16'h3C00, 4'b1100, 2'b01);
      req_valid = 2'b01;
      rsp_ready = 1'b0;
      #1 chk("bp.ready", 32'(req_ready), 1);
      tick();
      req_valid = 2'b10;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp.rsp_valid", 32'(rsp_valid), 1);
         chk("bp.rsp", {rsp_result, rsp_flags, 11'd0, rsp_id}, {16'h4200, 4'h0, 12'd0});
         chk("bp.req_ready", 32'(req_ready), 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp.idle_ready", 32'(req_ready), 2);
      tick();
      req_valid = 2'b00;
      chk("mid.fma_x", 32'(fma_x), 32'h3C01);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid.reset_out", {rsp_valid, req_ready, rsp_id, rsp_flags, rsp_result, 8'd0}, 0);
      chk("mid.reset_fma", {fma_x, fma_op, fma_rm, 10'd0}, 0);
      chk("mid.reset_sticky", 32'(flag_sticky), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mid.no_rsp", 32'(rsp_valid), 0);
      end

      b_req_x[15:0] = 16'h3C00;
      b_req_y[15:0] = 16'h4000;
      b_req_z[15:0] = 16'h3C00;
      b_req_op[3:0] = 4'b1100;
      b_req_rm[1:0] = 2'b01;
      b_req_valid = 2'b01;
      #1 chk("lat3.ready", 32'(b_req_ready), 1);
      tick();
      b_req_valid = 2'b00;
      for (int k = 0; k < 3; k++) begin
         chk("lat3.busy_valid", 32'(b_rsp_valid), 0);
         chk("lat3.fma_rm", 32'(b_fma_rm), 1);
         tick();
      end
      chk("lat3.rsp_valid", 32'(b_rsp_valid), 1);
      chk("lat3.rsp_result", 32'(b_rsp_result), 32'h4200);
      chk("lat3.rsp_id", 32'(b_rsp_id), 0);
      tick();
      chk("lat3.done", 32'(b_rsp_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fma16_arb.md
# fma16_arb

Round-robin arbiter and sequencer that shares one multi-cycle fma16 datapath between `NREQ` requesters. It accepts operations over per-requester valid/ready handshakes, latches the winner's operands and rounding mode, and drives them to the datapath for `LAT` cycles. It then captures result and flags and returns them on a tagged response handshake. It also keeps a per-requester sticky exception-flag register, analogous to `fflags`, and sits between the issuing agents and the fma16 core.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `LAT`, default 1: datapath latency in cycles from operand drive to valid `fma_result`/`fma_flags`, 1..15.

Ports:
- `clk`  in  1  clock; everything samples on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_ready`  out  NREQ  request accepted, one-hot or zero.
- `req_x`, `req_y`, `req_z`  in  16*NREQ  half-precision operands; requester i occupies bits [16i+15:16i].
- `req_op`  in  4*NREQ  {mul, add, negp, negz} per requester.
- `req_rm`  in  2*NREQ  roundmode: 00 RZ, 01 RNE, 10 toward −inf, 11 toward +inf.
- `fma_x`, `fma_y`, `fma_z`  out  16  operands to the datapath.
- `fma_op`  out  4  {mul, add, negp, negz} to the datapath.
- `fma_rm`  out  2  roundmode to the datapath.
- `fma_result`  in  16  datapath result.
- `fma_flags`  in  4  datapath flags {nv, of, uf, nx}.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accepted.
- `rsp_id`  out  $clog2(NREQ)  index of the requester that owns the response.
- `rsp_result`  out  16  captured result.
- `rsp_flags`  out  4  captured flags for this operation.
- `flag_clr`  in  NREQ  clear the sticky flags of requester i.
- `flag_sticky`  out  4*NREQ  sticky {nv, of, uf, nx} per requester.

## Operation
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - If any `req_valid` is set, the grant goes to the first valid index strictly after `last_grant`, searching cyclically.
  - `req_ready[grant]` is asserted combinationally in that same cycle.
  - On the edge, the block latches operands, op, rm and id, sets `last_grant`=grant, loads `cnt`=LAT-1, and moves to BUSY.
- BUSY:
  - `fma_*` outputs are driven from the latched registers.
  - `cnt` decrements each cycle.
  - When `cnt`==0, the block captures `fma_result`/`fma_flags` into the `rsp_*` registers, ORs the flags into `flag_sticky[id]`, and moves to RESP.
- RESP:
  - `rsp_valid`=1 and all `rsp_*` outputs are held stable.
  - When `rsp_valid & rsp_ready`, the FSM returns to IDLE.
  - No new grant is made in RESP; arbitration resumes the cycle after return to IDLE.
- `req_ready` is 0 in every state except IDLE. Requesters must hold their operands stable while `req_valid` is high and not yet accepted.
- In IDLE, `fma_*` outputs hold their last latched values and do not toggle.
- `flag_clr[i]` clears `flag_sticky[i]` on the next edge.
  - If a clear and a capture for the same requester fall on the same edge, the register takes only the new flags (clear first, then OR).
  - A clear for a different requester is independent of any capture.
- Reset (`reset`=1):
  - FSM goes to IDLE, `last_grant`=NREQ-1 (so requester 0 wins first), `cnt`=0.
  - All `rsp_*` registers, `fma_*` registers and `flag_sticky` are zeroed.
  - An in-flight operation is dropped and produces no response.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0x0000, `rsp_flags`=0, `flag_sticky`=0, all `fma_*`=0.
- Accept at edge A. BUSY covers cycles A+1..A+LAT. `rsp_valid` rises in cycle A+LAT+1.
- Minimum issue interval is LAT+2 cycles when `rsp_ready` is held high.
- The sticky update is visible on `flag_sticky` in the same cycle `rsp_valid` rises.
- The grant is purely combinational from `req_valid` and `last_grant`. There is no combinational path from `rsp_ready` or `fma_*` to `req_ready`.

## Configuration
- `FMA16_ARB_STICKY_EN` defined: `flag_sticky` registers and `flag_clr` behave as described above.
- Not defined: no sticky registers are built, `flag_sticky` is tied to 0, and `flag_clr` is ignored. `rsp_flags` is unaffected.

## Test plan
- Single op, LAT=1, requester 0: x=0x3C00, y=0x4000, z=0x3C00, op=1100, rm=01.
  - Required: `req_ready[0]` high in the accept cycle, `rsp_valid` 2 cycles later, `rsp_result`=0x4200, `rsp_flags`=0, `rsp_id`=0.
- Roundmode passthrough: x=y=0x3C01, op=1000.
  - Required: rm=00 gives 0x3C02 with flags 0001; rm=11 gives 0x3C03 with flags 0001. `fma_rm` matches the latched rm throughout BUSY.
- Round-robin: both requesters hold `req_valid` continuously from reset, with `rsp_ready`=1.
  - Required: grants go 0,1,0,1, and `rsp_id` follows the same order.
- Sticky flags: requester 1 issues 0x7BFF × 0x4000, rm=01.
  - Required: result 0x7C00, `rsp_flags`=0101, `flag_sticky[7:4]`=0101. Then assert `flag_clr[1]` on the capture edge of an exact op (flags 0000); `flag_sticky[7:4]` must be 0000.
- Backpressure and reset: hold `rsp_ready`=0 for 5 cycles in RESP.
  - Required: outputs stable and `req_ready`=0 throughout.
  - Then assert `reset` mid-BUSY of the next op: `rsp_valid` never asserts for it and all outputs return to their reset values.
- LAT=3: same op as the first scenario.
  - Required: `rsp_valid` rises exactly 4 cycles after the accept edge.
